uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver: the receive end of the board's 8N1 UART link, the counterpart to the `uart_tx` pin on the PYNQ-Z2 top level. It samples the `rx` pin in the `cpu_clk` domain and validates start and stop bits. It buffers received bytes in a first-word-fall-through queue that the data-memory MMIO decoder drains. Framing and overrun errors are reported as sticky flags for software to poll and clear.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 87: `cpu_clk` cycles per bit (10 MHz / 115200). Minimum 4.
- `FIFO_DEPTH`, default 4: receive queue depth; must be a power of two ≥ 2. Used only with `UART_RX_FIFO_EN`.

Ports:
- `clk` input 1: CPU clock. The block has one clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line, asynchronous, idle high.
- `rd_en` input 1: pop the head byte. Ignored when `rx_valid`=0.
- `rd_data` output 8: head byte, valid while `rx_valid`=1.
- `rx_valid` output 1: queue non-empty.
- `frame_err` output 1: sticky; stop bit sampled low.
- `overrun` output 1: sticky; byte dropped because the queue was full.
- `err_clr` input 1: clears both sticky flags.
- `busy` output 1: FSM is not in IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer. Both flops reset to 1. All FSM decisions use the synchronized value `rx_s`.
- FSM states:
  - IDLE → START when `rx_s`=0; counter cleared.
  - START: counts to `CLKS_PER_BIT/2 - 1`, which is mid start bit.
    - `rx_s`=0 → DATA, counter cleared, `bit_idx`=0.
    - `rx_s`=1 → IDLE (glitch rejected, nothing recorded).
  - DATA: at counter `CLKS_PER_BIT-1`, shift `rx_s` into the MSB of the shift register (LSB-first on the wire).
    - `bit_idx` increments; counter cleared.
    - After bit 7 → STOP.
  - STOP: at counter `CLKS_PER_BIT-1`, sample `rx_s`.
    - 1 → push the byte, → IDLE.
    - 0 → set `frame_err`, discard the byte, → BREAK.
  - BREAK → IDLE when `rx_s`=1. This prevents a held-low line from re-triggering START.
- Push when the queue is full: drop the byte and set `overrun`; queue contents unchanged.
- Push and pop in the same cycle: always legal, including when full. The pop frees the slot, the push lands, and `overrun` stays clear.
- `err_clr` clears both flags. If a new error occurs in the same cycle, set wins.
- Counter width is `$clog2(CLKS_PER_BIT)`. The counter never wraps: it is cleared on every state transition.

## Timing
- Reset values:
  - `rd_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - FSM=IDLE; queue empty.
- Reset asserted mid-frame: the partial byte is lost and the queue is flushed. After release, the FSM waits in IDLE for the next falling edge.
- Latency from `rx` falling to START: 2 synchronizer cycles + 1 FSM cycle.
- `rx_valid` rises the cycle after the stop-bit sample.
- `rd_data` is combinational from the queue head.
- Pop takes effect at the `clk` edge where `rd_en`=1; the next head byte (or `rx_valid`=0) is visible the following cycle.
- Back-to-back frames: a new START may begin in the cycle after STOP → IDLE, so no idle bits are required.
- `busy` is registered and follows the FSM state.

## Configuration
- `UART_RX_FIFO_EN` defined: `FIFO_DEPTH`-entry circular queue with read/write pointers one bit wider than the index, so full and empty are distinguishable.
- `UART_RX_FIFO_EN` undefined:
  - Single holding register; `FIFO_DEPTH` is ignored.
  - A second byte arriving before the pop sets `overrun` and is dropped.
  - Push and pop in the same cycle when held behaves as above: the new byte is accepted.
- All other behaviour is identical in both builds.

## Structure
- `riscv_pkg` holds:
  - `uart_rx_state_t` enum (IDLE, START, DATA, STOP, BREAK).
  - `UART_CLKS_PER_BIT` constant (87).
  - `UART_RX_ADDR` MMIO constant, for the DataMemory decoder.
- Sub-module `uart_rx_fifo` provides the queue. Parameter `DEPTH`; ports push, pop, `din`, `dout`, `empty`, `full`. It is instantiated only under `UART_RX_FIFO_EN`.

## Test plan
- **Single frame:** with `CLKS_PER_BIT`=16, drive frame 0x55 → `rx_valid`=1 the cycle after the stop sample; `rd_data`=0x55; one `rd_en` pulse gives `rx_valid`=0.
- **Back-to-back frames:** 0xA5 then 0x3C with no idle bits, no pops → queue holds 0xA5 then 0x3C in order; no error flags.
- **Glitch rejection:** `rx` low for 5 cycles (less than `CLKS_PER_BIT/2`) → FSM returns to IDLE; no byte, no flags.
- **Framing error and break:** frame 0x12 with stop bit low, then line held low for 100 cycles → `frame_err`=1, no byte, FSM stays in BREAK. Release the line, send 0x34 → 0x34 received. `err_clr` clears `frame_err`.
- **Overrun:** with the FIFO enabled and depth 4, send 5 bytes 0x01–0x05 without popping → 0x01–0x04 retained, `overrun`=1. Repeat with a pop on the 5th push cycle → `overrun`=0 and 0x05 is retained.
- **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3 → all outputs return to reset values immediately. After release, send 0x7E → 0x7E received cleanly.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the CPU codebase slice that hosts the
// UART receiver.
//   uart_rx_state_t   : receiver FSM state encoding
//   UART_CLKS_PER_BIT : cpu_clk cycles per bit (10 MHz / 115200)
//   UART_RX_ADDR      : MMIO address decoded by DataMemory for the RX port
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  localparam int UART_CLKS_PER_BIT = 87;

  localparam logic [31:0] UART_RX_ADDR = 32'h0000_FF08;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte queue for the UART receiver.
// Read/write pointers carry one extra wrap bit so full and empty differ.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and byte (dropped when full unless popping)
//   pop        : remove head byte (ignored when empty)
//   dout       : head byte, 0 when empty
//   empty,full : queue status
module uart_rx_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [7:0]  mem_r [DEPTH];
  logic        do_pop_s;
  logic        do_push_s;

  // A pop in the same cycle frees the slot, so a push into a full queue lands.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    if (empty) begin
      dout = 8'h00;
    end else begin
      dout = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Pointer and storage update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= din;
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with sticky error flags.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry receive queue;
// otherwise a single holding register buffers one byte.
// Ports:
//   clk, rst_n : cpu_clk, asynchronous active-low reset
//   rx         : serial line, idle high, asynchronous to clk
//   rd_en      : pop head byte (ignored while rx_valid=0)
//   rd_data    : head byte, valid while rx_valid=1
//   rx_valid   : receive buffer non-empty
//   frame_err  : sticky, stop bit sampled low
//   overrun    : sticky, byte dropped because the buffer was full
//   err_clr    : clears both sticky flags (a same-cycle new error wins)
//   busy       : FSM is not in IDLE
module uart_rx
  import riscv_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  // Elaboration-time guard on parameter ranges.
  if (CLKS_PER_BIT < 4 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_rx: CLKS_PER_BIT must be >= 4, FIFO_DEPTH a power of two >= 2");
  end

  logic           sync1_r;
  logic           rx_s;
  uart_rx_state_t state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]     bit_idx_r;
  logic [7:0]     shift_r;
  logic           busy_r;
  logic           frame_err_r;
  logic           overrun_r;
  logic           stop_last_s;
  logic           push_s;
  logic           ferr_s;
  logic           pop_s;
  logic           full_s;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= rx;
      rx_s    <= sync1_r;
    end
  end

  // Stop-bit sample produces either a push or a framing error this cycle.
  always_comb begin
    stop_last_s = (state_r == STOP) && (cnt_r == BIT_LAST);
    push_s      = stop_last_s & rx_s;
    ferr_s      = stop_last_s & ~rx_s;
    pop_s       = rd_en & rx_valid;
  end

  // Receiver FSM; busy is registered alongside every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (!rx_s) begin
            state_r <= START;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r <= '0;
            if (!rx_s) begin
              state_r   <= DATA;
              bit_idx_r <= 3'd0;
            end else begin
              // Start bit vanished before mid-bit: treat as a glitch.
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r     <= '0;
            // LSB arrives first, so shifting in from the top leaves it at bit 0.
            shift_r   <= {rx_s, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r <= '0;
            if (rx_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= BREAK;
            end
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        BREAK: begin
          // Wait for the line to return high so a held-low line cannot restart.
          cnt_r <= '0;
          if (rx_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic empty_s;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (shift_r),
    .dout  (rd_data),
    .empty (empty_s),
    .full  (full_s)
  );

  assign rx_valid = ~empty_s;
`else
  logic [7:0] hold_r;
  logic       hold_valid_r;

  // Single-entry buffer; a same-cycle pop makes room for the incoming byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r       <= 8'h00;
      hold_valid_r <= 1'b0;
    end else begin
      if (push_s && (!hold_valid_r || pop_s)) begin
        hold_r       <= shift_r;
        hold_valid_r <= 1'b1;
      end else if (pop_s) begin
        hold_valid_r <= 1'b0;
      end
    end
  end

  // Head byte is forced to zero while empty.
  always_comb begin
    full_s   = hold_valid_r;
    rx_valid = hold_valid_r;
    if (hold_valid_r) begin
      rd_data = hold_r;
    end else begin
      rd_data = 8'h00;
    end
  end
`endif

  // Sticky error flags: clear request loses to a new error in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= (frame_err_r & ~err_clr) | ferr_s;
      overrun_r   <= (overrun_r & ~err_clr) | (push_s & full_s & ~pop_s);
    end
  end

  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Stimulus pushes expected bytes into exp_q; a monitor pops and compares each
// byte the DUT hands out when rd_en and rx_valid are both high.
// Works with or without UART_RX_FIFO_EN (buffer capacity adapts).
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic       busy;

  int         total;
  int         bad;
  int         cyc;
  int         rise_cyc;
  int         start_cyc;
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: pops the scoreboard whenever the DUT hands out a byte.
  initial begin
    logic       prev_v;
    logic [7:0] exp_b;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && rx_valid && !prev_v) rise_cyc = cyc;
      prev_v = rx_valid;
      if (rst_n && rd_en && rx_valid) begin
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL rd_data_unexpected: got %02h, expected no byte", rd_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (rd_data !== exp_b) begin
            bad = bad + 1;
            $display("FAIL rd_data: got %02h, expected %02h", rd_data, exp_b);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; optional rd_en pulse at cycle pop_at, optional reset at abort_at.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int pop_at, input int abort_at);
    logic [9:0] bits;
    bits      = {stop_bit, b, 1'b0};
    start_cyc = cyc;
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c == abort_at) begin
        rst_n = 1'b0;
        rx    = 1'b1;
        rd_en = 1'b0;
        return;
      end
      rx    = bits[c / CPB];
      rd_en = (c == pop_at);
      @(posedge clk);
      #1;
    end
    rd_en = 1'b0;
  endtask

  task automatic drain(input string name);
    logic ok;
    ok    = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 4; i++) begin
      @(posedge clk);
      #1;
      if (!rx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    rd_en = 1'b0;
    chk({name, "_drained"}, {31'd0, ok}, 32'd1);
    chk({name, "_leftover"}, exp_q.size(), 32'd0);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    wait_cycles(1);
    err_clr = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rise_cyc = -1;
    rst_n   = 1'b0;
    rx      = 1'b1;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    #1;
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_rd_data", {24'd0, rd_data}, 32'h00);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_cycles(3);

    // Single frame with exact rx_valid latency (stop sample at cycle 155).
    rise_cyc = -1;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, -1, -1);
    chk("single_latency", rise_cyc - start_cyc, 32'd155);
    chk("single_valid", {31'd0, rx_valid}, 32'd1);
    chk("single_data", {24'd0, rd_data}, 32'h55);
    chk("single_busy", {31'd0, busy}, 32'd0);
    rd_en = 1'b1;
    wait_cycles(1);
    rd_en = 1'b0;
    chk("single_popped", {31'd0, rx_valid}, 32'd0);

    // Back-to-back frames, no idle bits, no pops.
    exp_q.push_back(8'hA5);
    if (CAP > 1) exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1, -1, -1);
    send_frame(8'h3C, 1'b1, -1, -1);
    chk("b2b_overrun", {31'd0, overrun}, (CAP > 1) ? 32'd0 : 32'd1);
    chk("b2b_frame_err", {31'd0, frame_err}, 32'd0);
    drain("b2b");
    clear_errs();

    // Glitch shorter than half a bit.
    rx = 1'b0;
    wait_cycles(4);
    chk("glitch_busy_start", {31'd0, busy}, 32'd1);
    wait_cycles(1);
    rx = 1'b1;
    wait_cycles(20);
    chk("glitch_busy_idle", {31'd0, busy}, 32'd0);
    chk("glitch_no_byte", {31'd0, rx_valid}, 32'd0);
    chk("glitch_frame_err", {31'd0, frame_err}, 32'd0);
    chk("glitch_overrun", {31'd0, overrun}, 32'd0);

    // Framing error followed by a held-low line.
    send_frame(8'h12, 1'b0, -1, -1);
    wait_cycles(100);
    chk("ferr_flag", {31'd0, frame_err}, 32'd1);
    chk("ferr_no_byte", {31'd0, rx_valid}, 32'd0);
    chk("ferr_break_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    wait_cycles(5);
    chk("ferr_released", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h34);
    send_frame(8'h34, 1'b1, -1, -1);
    chk("ferr_sticky", {31'd0, frame_err}, 32'd1);
    drain("ferr");
    clear_errs();
    chk("ferr_cleared", {31'd0, frame_err}, 32'd0);

    // Overrun: one more byte than the buffer holds.
    for (int i = 1; i <= CAP + 1; i++) begin
      if (i <= CAP) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, -1, -1);
    end
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_frame_err", {31'd0, frame_err}, 32'd0);
    drain("ovr");
    clear_errs();
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Same again with a pop on the cycle of the last push.
    for (int i = 1; i <= CAP + 1; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, (i == CAP + 1) ? 154 : -1, -1);
    end
    chk("ovr_pop_flag", {31'd0, overrun}, 32'd0);
    chk("ovr_pop_valid", {31'd0, rx_valid}, 32'd1);
    drain("ovr_pop");

    // Reset during data bit 3 with a byte buffered and frame_err set.
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h66, 1'b0, -1, -1);
    rx = 1'b1;
    wait_cycles(3);
    chk("pre_rst_frame_err", {31'd0, frame_err}, 32'd1);
    chk("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
    send_frame(8'h7E, 1'b1, -1, 70);
    #1;
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(5);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, -1, -1);
    chk("post_rst_frame_err", {31'd0, frame_err}, 32'd0);
    drain("post_rst");

    wait_cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
